// File: rtl/pixel_calc_pkg.sv
// Shared types and constants for the pixel_calc Sobel engine.
// Coefficient tables are indexed by tap; tap t covers window row t/3, column t%3.
package pixel_calc_pkg;

  localparam int DEF_PIX_W = 8;
  localparam int DEF_ACC_W = 11;
  localparam int TAPS      = 9;

  localparam logic [3:0] LAST_TAP = 4'd8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    MAG   = 3'd2,
    DONE  = 3'd3,
    HOLD  = 3'd4
  } calc_state_t;

  localparam logic signed [2:0] GX_COEF [0:TAPS-1] = '{
    3'sb111, 3'sb000, 3'sb001,
    3'sb110, 3'sb000, 3'sb010,
    3'sb111, 3'sb000, 3'sb001
  };

  localparam logic signed [2:0] GY_COEF [0:TAPS-1] = '{
    3'sb111, 3'sb110, 3'sb111,
    3'sb000, 3'sb000, 3'sb000,
    3'sb001, 3'sb010, 3'sb001
  };

  // Output pixel index (row in bit 1, column in bit 0) for a select value 1..4.
  function automatic logic [1:0] sel_to_index(input logic [2:0] sel);
    logic [1:0] idx;
    case (sel)
      3'd1:    idx = 2'd0;
      3'd2:    idx = 2'd1;
      3'd3:    idx = 2'd2;
      3'd4:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/pixel_calc_sobel_tap.sv
// Combinational single-tap Sobel term: picks the window pixel for (cur_sel, tap)
// and weights it by the Gx and Gy coefficients of that tap.
module sobel_tap
  import pixel_calc_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [16*PIX_W-1:0]      pix_block,
  input  logic [2:0]               cur_sel,
  input  logic [3:0]               tap,
  output logic signed [ACC_W-1:0]  gx_term,
  output logic signed [ACC_W-1:0]  gy_term
);

  logic [1:0]              k_s;
  logic [1:0]              dr_s;
  logic [1:0]              dc_s;
  logic [1:0]              row_s;
  logic [1:0]              col_s;
  logic [3:0]              pix_idx_s;
  logic [PIX_W-1:0]        pix_s;
  logic signed [2:0]       cx_s;
  logic signed [2:0]       cy_s;

  // Coefficients are restricted to -2..2, so weighting is a shift and negate.
  function automatic logic signed [ACC_W-1:0] weight(input logic signed [2:0] coef,
                                                     input logic [PIX_W-1:0] pix);
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] res;
    ext = $signed({{(ACC_W-PIX_W){1'b0}}, pix});
    case (coef)
      3'sb001: res = ext;
      3'sb010: res = ext <<< 1;
      3'sb111: res = -ext;
      3'sb110: res = -(ext <<< 1);
      default: res = {ACC_W{1'b0}};
    endcase
    return res;
  endfunction

  // Decompose tap into window row/column offsets.
  always_comb begin
    dr_s = 2'd0;
    dc_s = 2'd0;
    case (tap)
      4'd0:    begin dr_s = 2'd0; dc_s = 2'd0; end
      4'd1:    begin dr_s = 2'd0; dc_s = 2'd1; end
      4'd2:    begin dr_s = 2'd0; dc_s = 2'd2; end
      4'd3:    begin dr_s = 2'd1; dc_s = 2'd0; end
      4'd4:    begin dr_s = 2'd1; dc_s = 2'd1; end
      4'd5:    begin dr_s = 2'd1; dc_s = 2'd2; end
      4'd6:    begin dr_s = 2'd2; dc_s = 2'd0; end
      4'd7:    begin dr_s = 2'd2; dc_s = 2'd1; end
      4'd8:    begin dr_s = 2'd2; dc_s = 2'd2; end
      default: begin dr_s = 2'd0; dc_s = 2'd0; end
    endcase
  end

  // Locate the pixel and fetch the coefficients for this tap.
  always_comb begin
    k_s       = sel_to_index(cur_sel);
    row_s     = {1'b0, k_s[1]} + dr_s;
    col_s     = {1'b0, k_s[0]} + dc_s;
    pix_idx_s = {row_s, col_s};
    pix_s     = pix_block[PIX_W*pix_idx_s +: PIX_W];
    if (tap <= LAST_TAP) begin
      cx_s = GX_COEF[tap];
      cy_s = GY_COEF[tap];
    end else begin
      cx_s = 3'sb000;
      cy_s = 3'sb000;
    end
    gx_term = weight(cx_s, pix_s);
    gy_term = weight(cy_s, pix_s);
  end

endmodule

// File: rtl/pixel_calc.sv
// Sobel gradient-magnitude engine: one kernel tap per cycle for the selected
// output pixel, then a saturated |Gx|+|Gy| result and a one-cycle calc_done.
module pixel_calc
  import pixel_calc_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_enable,
  input  logic                 calc_enable,
  input  logic [2:0]           select,
  input  logic [16*PIX_W-1:0]  pix_block,
  output logic                 calc_done,
  output logic [PIX_W-1:0]     pix_out,
  output logic [1:0]           out_index
);

  calc_state_t              state_r;
  calc_state_t              state_nxt_s;
  logic                     start_s;
  logic                     sel_valid_s;
  logic [2:0]               cur_sel_r;
  logic [3:0]               tap_r;
  logic signed [ACC_W-1:0]  gx_r;
  logic signed [ACC_W-1:0]  gy_r;
  logic signed [ACC_W-1:0]  gx_term_s;
  logic signed [ACC_W-1:0]  gy_term_s;
  logic [ACC_W-1:0]         abs_gx_s;
  logic [ACC_W-1:0]         abs_gy_s;
  logic [ACC_W:0]           mag_s;
  logic [PIX_W-1:0]         sat_s;
  logic                     calc_done_r;
  logic [PIX_W-1:0]         pix_out_r;
  logic [1:0]               out_index_r;

  sobel_tap #(
    .PIX_W (PIX_W),
    .ACC_W (ACC_W)
  ) u_sobel_tap (
    .pix_block (pix_block),
    .cur_sel   (cur_sel_r),
    .tap       (tap_r),
    .gx_term   (gx_term_s),
    .gy_term   (gy_term_s)
  );

  assign sel_valid_s = (select >= 3'd1) && (select <= 3'd4);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a load aborts everything outside IDLE.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    if (load_enable && (state_r != IDLE)) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (calc_enable && sel_valid_s && !load_enable) begin
            state_nxt_s = ACCUM;
            start_s     = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        ACCUM: begin
          if (tap_r == LAST_TAP) begin
            state_nxt_s = MAG;
          end else begin
            state_nxt_s = ACCUM;
          end
        end
        MAG:  state_nxt_s = DONE;
        DONE: state_nxt_s = HOLD;
        HOLD: begin
          // Same select as the one just finished must not recompute.
          if (!calc_enable) begin
            state_nxt_s = IDLE;
          end else if ((select != cur_sel_r) && sel_valid_s) begin
            state_nxt_s = ACCUM;
            start_s     = 1'b1;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Saturated magnitude of the finished accumulators.
  always_comb begin
    abs_gx_s = gx_r[ACC_W-1] ? $unsigned(-gx_r) : $unsigned(gx_r);
    abs_gy_s = gy_r[ACC_W-1] ? $unsigned(-gy_r) : $unsigned(gy_r);
    mag_s    = {1'b0, abs_gx_s} + {1'b0, abs_gy_s};
    if (mag_s > {{(ACC_W+1-PIX_W){1'b0}}, {PIX_W{1'b1}}}) begin
      sat_s = {PIX_W{1'b1}};
    end else begin
      sat_s = mag_s[PIX_W-1:0];
    end
  end

  // Tap counter, accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_sel_r   <= 3'd0;
      tap_r       <= 4'd0;
      gx_r        <= {ACC_W{1'b0}};
      gy_r        <= {ACC_W{1'b0}};
      calc_done_r <= 1'b0;
      pix_out_r   <= {PIX_W{1'b0}};
      out_index_r <= 2'd0;
    end else begin
      calc_done_r <= (state_r == DONE) && !load_enable;
      if (start_s) begin
        cur_sel_r <= select;
        tap_r     <= 4'd0;
        gx_r      <= {ACC_W{1'b0}};
        gy_r      <= {ACC_W{1'b0}};
      end else if ((state_r == ACCUM) && !load_enable) begin
        gx_r  <= gx_r + gx_term_s;
        gy_r  <= gy_r + gy_term_s;
        tap_r <= (tap_r == LAST_TAP) ? 4'd0 : tap_r + 4'd1;
      end
      if ((state_r == MAG) && !load_enable) begin
        pix_out_r   <= sat_s;
        out_index_r <= sel_to_index(cur_sel_r);
      end
    end
  end

  assign calc_done = calc_done_r;
  assign pix_out   = pix_out_r;
  assign out_index = out_index_r;

endmodule

// File: tb/tb_pixel_calc.sv
// Directed self-checking bench for pixel_calc: ramps, saturation, abort,
// invalid/held selects and mid-calculation reset with hand-computed results.
module tb_pixel_calc;
  import pixel_calc_pkg::*;

  logic         clk;
  logic         rst;
  logic         load_enable;
  logic         calc_enable;
  logic [2:0]   select;
  logic [127:0] pix_block;
  logic         calc_done;
  logic [7:0]   pix_out;
  logic [1:0]   out_index;

  int checks;
  int failures;
  int pulse_cnt;
  int cnt0;
  int lat;

  pixel_calc dut (
    .clk         (clk),
    .rst         (rst),
    .load_enable (load_enable),
    .calc_enable (calc_enable),
    .select      (select),
    .pix_block   (pix_block),
    .calc_done   (calc_done),
    .pix_out     (pix_out),
    .out_index   (out_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (calc_done === 1'b1) pulse_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0 flat 100, 1: 10c, 2: 10r, 3: 10r+10c, 4: cols 2-3 = 255
  task automatic set_block(input int mode);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        case (mode)
          0:       pix_block[8*(4*r+c) +: 8] = 8'd100;
          1:       pix_block[8*(4*r+c) +: 8] = 8'(10*c);
          2:       pix_block[8*(4*r+c) +: 8] = 8'(10*r);
          3:       pix_block[8*(4*r+c) +: 8] = 8'(10*r + 10*c);
          default: pix_block[8*(4*r+c) +: 8] = (c >= 2) ? 8'd255 : 8'd0;
        endcase
      end
    end
  endtask

  // Edges counted from the start edge (edge 1) to the edge that raises calc_done.
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 40) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (calc_done === 1'b1) break;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Four-pixel pass; selector advances one cycle after each calc_done.
  task automatic run_pass(input string name, input logic [7:0] exp_pix);
    for (int k = 1; k <= 4; k++) begin
      select      = 3'(k);
      calc_enable = 1'b1;
      wait_done(lat);
      check($sformatf("%s_lat%0d", name, k), lat, 12);
      check($sformatf("%s_pix%0d", name, k), pix_out, exp_pix);
      check($sformatf("%s_idx%0d", name, k), out_index, k - 1);
      @(posedge clk);
      @(negedge clk);
    end
    calc_enable = 1'b0;
    select      = 3'd0;
    cycles(2);
  endtask

  initial begin
    checks = 0; failures = 0; pulse_cnt = 0;
    rst = 1'b1; load_enable = 1'b0; calc_enable = 1'b0; select = 3'd0;
    set_block(0);
    @(negedge clk);
    cycles(2);
    check("rst_done", calc_done, 0);
    check("rst_pix", pix_out, 0);
    check("rst_idx", out_index, 0);
    rst = 1'b0;
    cycles(1);

    set_block(0); run_pass("flat", 8'd0);
    set_block(1); run_pass("ramp_c", 8'd80);
    set_block(2); run_pass("ramp_r", 8'd80);
    set_block(3); run_pass("ramp_rc", 8'd160);
    set_block(4); run_pass("sat", 8'd255);

    // Abort while tap 4 of pixel 1 is pending.
    set_block(1);
    cnt0        = pulse_cnt;
    select      = 3'd1;
    calc_enable = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    load_enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_done", calc_done, 0);
    check("abort_pix", pix_out, 255);
    check("abort_state", dut.state_r, IDLE);
    load_enable = 1'b0;
    wait_done(lat);
    check("abort_no_pulse", pulse_cnt - cnt0, 0);
    check("abort_restart_lat", lat, 12);
    check("abort_restart_pix", pix_out, 80);
    check("abort_restart_idx", out_index, 0);
    @(posedge clk);
    @(negedge clk);
    calc_enable = 1'b0;
    cycles(2);

    // Invalid selects never start a calculation.
    cnt0 = pulse_cnt;
    calc_enable = 1'b1;
    select = 3'd0; cycles(15);
    select = 3'd5; cycles(15);
    select = 3'd7; cycles(15);
    check("invalid_pulses", pulse_cnt - cnt0, 0);
    check("invalid_state", dut.state_r, IDLE);
    check("invalid_pix", pix_out, 80);

    // Held select gives exactly one pulse.
    cnt0   = pulse_cnt;
    select = 3'd2;
    cycles(30);
    check("hold_pulses", pulse_cnt - cnt0, 1);
    check("hold_idx", out_index, 1);
    check("hold_state", dut.state_r, HOLD);
    calc_enable = 1'b0;
    select      = 3'd0;
    cycles(2);

    // Reset during ACCUM, then a clean restart.
    set_block(3);
    select      = 3'd3;
    calc_enable = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_done", calc_done, 0);
    check("mrst_pix", pix_out, 0);
    check("mrst_idx", out_index, 0);
    check("mrst_state", dut.state_r, IDLE);
    rst = 1'b0;
    wait_done(lat);
    check("mrst_restart_lat", lat, 12);
    check("mrst_restart_pix", pix_out, 160);
    check("mrst_restart_idx", out_index, 2);
    calc_enable = 1'b0;
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
